// File: rtl/coarse_gain_controller_pkg.sv
// Shared widths, state encoding and magnitude helper for the coarse gain
// scheduler and its window peak detector.
package coarse_gain_controller_pkg;

  localparam int ADJ_W  = 3;
  localparam int DATA_W = 14;
  localparam int PEAK_W = 21;

  localparam logic [ADJ_W-1:0]  ADJ_MAX = 3'd7;
  localparam logic [DATA_W-1:0] MAG_MAX = 14'd8191;

  typedef enum logic [1:0] {
    MANUAL  = 2'd0,
    ACQUIRE = 2'd1,
    DECIDE  = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  // |x| in DATA_W bits; the most negative code would not fit, so it saturates.
  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      r = MAG_MAX;
    else if (x[DATA_W-1])
      r = $unsigned(-x);
    else
      r = $unsigned(x);
    return r;
  endfunction

endpackage

// File: rtl/coarse_gain_controller_window_peak_detector.sv
// Per-window peak hold of the shifted sample magnitude, with a valid-sample
// window counter that flags the sample completing each window.
module window_peak_detector
  import coarse_gain_controller_pkg::*;
#(
  parameter int WIN_LOG2 = 10
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic        [ADJ_W-1:0]  adj_i,
  output logic        [PEAK_W-1:0] shift_mag_o,
  output logic                     done_o,
  output logic        [PEAK_W-1:0] peak_o
);

  logic [DATA_W-1:0]   mag;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [PEAK_W-1:0]   peak_q;

  assign mag         = sat_abs(data_i);
  assign shift_mag_o = PEAK_W'(mag) << adj_i;
  assign done_o      = en_i && valid_i && (win_cnt == {WIN_LOG2{1'b1}});
  assign peak_o      = peak_q;

  // clear wins over accumulate so a window-closing sample can be discarded
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      win_cnt <= '0;
      peak_q  <= '0;
    end else if (clear_i) begin
      win_cnt <= '0;
      peak_q  <= '0;
    end else if (en_i && valid_i) begin
      win_cnt <= win_cnt + 1'b1;
      if (shift_mag_o > peak_q)
        peak_q <= shift_mag_o;
    end
  end

endmodule

// File: rtl/coarse_gain_controller.sv
// Coarse shift scheduler: measures windowed peaks and steps adj_o with
// hysteresis and a settling hold-off; manual override and clip flag.
//
// state   | meaning
// MANUAL  | adj_o follows manual_adj_i, counters held clear
// ACQUIRE | accumulating peak over one window of valid samples
// DECIDE  | one cycle: publish peak, step adj_o up/down or keep it
// SETTLE  | discarding HOLD_WIN windows after a step
module coarse_gain_controller
  import coarse_gain_controller_pkg::*;
#(
  parameter int WIN_LOG2  = 10,
  parameter int HI_THRESH = 6144,
  parameter int LO_THRESH = 2048,
  parameter int HOLD_WIN  = 1,
  parameter int INIT_ADJ  = 0
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     valid_i,
  input  logic                     auto_i,
  input  logic        [ADJ_W-1:0]  manual_adj_i,
  output logic        [ADJ_W-1:0]  adj_o,
  output logic                     clip_o,
  output logic                     step_o,
  output logic        [PEAK_W-1:0] peak_o
);

  localparam int HOLD_W = (HOLD_WIN > 1) ? $clog2(HOLD_WIN) : 1;
  localparam logic [PEAK_W-1:0] HI_LIM = PEAK_W'(HI_THRESH);
  localparam logic [PEAK_W-1:0] LO_LIM = PEAK_W'(LO_THRESH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_WIN > 0) ? HOLD_WIN - 1 : 0);
  localparam state_t AFTER_STEP = (HOLD_WIN == 0) ? ACQUIRE : SETTLE;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                det_en;
  logic                det_clr;
  logic                win_done;
  logic [PEAK_W-1:0]   win_peak;
  logic [PEAK_W-1:0]   shift_mag;

  assign det_en  = auto_i && ((state == ACQUIRE) || (state == SETTLE));
  assign det_clr = !auto_i || (state == MANUAL) || (state == DECIDE) ||
                   ((state == SETTLE) && win_done);

  window_peak_detector #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_peak (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clear_i     (det_clr),
    .en_i        (det_en),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .adj_i       (adj_o),
    .shift_mag_o (shift_mag),
    .done_o      (win_done),
    .peak_o      (win_peak)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ACQUIRE;
      adj_o    <= ADJ_W'(INIT_ADJ);
      step_o   <= 1'b0;
      peak_o   <= '0;
      hold_cnt <= '0;
    end else begin
      step_o <= 1'b0;
      if (!auto_i) begin
        // override takes effect at once; any pending decision is dropped
        state    <= MANUAL;
        adj_o    <= manual_adj_i;
        hold_cnt <= '0;
      end else begin
        case (state)
          MANUAL: begin
            state    <= ACQUIRE;
            hold_cnt <= '0;
          end
          ACQUIRE: begin
            if (win_done)
              state <= DECIDE;
          end
          DECIDE: begin
            peak_o   <= win_peak;
            hold_cnt <= '0;
            if ((win_peak > HI_LIM) && (adj_o != '0)) begin
              adj_o  <= adj_o - 1'b1;
              step_o <= 1'b1;
              state  <= AFTER_STEP;
            end else if ((win_peak < LO_LIM) && (adj_o != ADJ_MAX)) begin
              adj_o  <= adj_o + 1'b1;
              step_o <= 1'b1;
              state  <= AFTER_STEP;
            end else begin
              state <= ACQUIRE;
            end
          end
          SETTLE: begin
            if (win_done) begin
              if (hold_cnt == HOLD_LAST) begin
                state    <= ACQUIRE;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: state <= ACQUIRE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      clip_o <= 1'b0;
    else
      clip_o <= valid_i && (shift_mag > PEAK_W'(MAG_MAX));
  end

endmodule

// File: tb/tb_coarse_gain_controller.sv
// Directed bench for coarse_gain_controller: step events are scored against
// a queue of hand-computed (adj, peak) pairs; static outputs checked inline.
module tb_coarse_gain_controller;

  logic               clk;
  logic               rstn;
  logic signed [13:0] data;
  logic               valid;
  logic               auto_en;
  logic        [2:0]  manual_adj;
  logic        [2:0]  adj;
  logic               clip;
  logic               step;
  logic        [20:0] peak;

  typedef struct {
    int adj;
    int peak;
  } step_exp_t;

  step_exp_t sb[$];
  step_exp_t cur;
  int vectors     = 0;
  int miscompares = 0;
  int step_cnt    = 0;
  int base;

  coarse_gain_controller dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .data_i       (data),
    .valid_i      (valid),
    .auto_i       (auto_en),
    .manual_adj_i (manual_adj),
    .adj_o        (adj),
    .clip_o       (clip),
    .step_o       (step),
    .peak_o       (peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input int p);
    step_exp_t e;
    e.adj  = a;
    e.peak = p;
    sb.push_back(e);
  endtask

  task automatic wait_steps(input int n, input int budget);
    int c = 0;
    while (step_cnt < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (step_cnt < n) begin
      vectors++;
      miscompares++;
      $display("FAIL step_timeout: got %0d steps expected %0d", step_cnt, n);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_adj", adj, 0);
    check("rst_clip", clip, 0);
    check("rst_step", step, 0);
    check("rst_peak", peak, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // scoreboard monitor: every step pulse must match the next expectation
  always @(negedge clk) begin
    if (rstn && step) begin
      step_cnt++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_step: adj=%0d peak=%0d (t=%0t)", adj, peak, $time);
      end else begin
        cur = sb.pop_front();
        check("step_adj", adj, cur.adj);
        check("step_peak", peak, cur.peak);
      end
    end
  end

  initial begin
    rstn       = 1'b0;
    data       = 14'sd100;
    valid      = 1'b1;
    auto_en    = 1'b1;
    manual_adj = 3'd0;

    // constant +100: climb 0..5 then hold with in-band peak 3200
    for (int k = 1; k <= 5; k++) push(k, 100 << (k - 1));
    do_reset();
    wait_steps(5, 12000);
    cycles(2200);
    check("s1_adj_hold", adj, 5);
    check("s1_peak", peak, 3200);
    check("s1_steps", step_cnt, 5);

    // most negative input at adj 0: over ceiling but cannot step down
    data = 14'sh2000;
    base = step_cnt;
    do_reset();
    cycles(600);
    check("s2_clip", clip, 0);
    cycles(600);
    check("s2_peak", peak, 8191);
    check("s2_adj", adj, 0);
    check("s2_steps", step_cnt, base);

    // zero input: climb to 7 and stop
    data = 14'sd0;
    base = step_cnt;
    for (int k = 1; k <= 7; k++) push(k, 0);
    do_reset();
    wait_steps(base + 7, 16000);
    cycles(2200);
    check("s3_adj", adj, 7);
    check("s3_peak", peak, 0);
    check("s3_steps", step_cnt, base + 7);

    // manual override then return to auto with an in-band signal
    base       = step_cnt;
    auto_en    = 1'b0;
    manual_adj = 3'd3;
    data       = 14'sd300;
    check("s4_adj_before", adj, 7);
    cycles(1);
    check("s4_adj_manual", adj, 3);
    auto_en = 1'b1;
    cycles(1100);
    check("s4_adj_hold", adj, 3);
    check("s4_peak", peak, 2400);
    check("s4_steps", step_cnt, base);

    // clip flag in manual mode
    auto_en    = 1'b0;
    manual_adj = 3'd5;
    cycles(2);
    check("s5_adj", adj, 5);
    check("s5_clip_9600", clip, 1);
    valid = 1'b0;
    cycles(1);
    check("s5_clip_invalid", clip, 0);
    valid = 1'b1;
    data  = -14'sd300;
    cycles(1);
    check("s5_clip_neg", clip, 1);
    manual_adj = 3'd4;
    data       = 14'sd300;
    cycles(2);
    check("s5_clip_4800", clip, 0);
    data = 14'sd512;
    cycles(1);
    check("s5_clip_8192", clip, 1);
    data = 14'sd511;
    cycles(1);
    check("s5_clip_8176", clip, 0);

    // reset mid-window at adj 4, then a full window before the first decision
    data    = 14'sd600;
    auto_en = 1'b1;
    cycles(300);
    check("s6_clip_pre", clip, 1);
    check("s6_adj_pre", adj, 4);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("s6_async_adj", adj, 0);
    check("s6_async_clip", clip, 0);
    data = 14'sd100;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push(1, 100);
    repeat (1024) @(posedge clk);
    @(negedge clk);
    check("s6_no_step_yet", step, 0);
    check("s6_adj_still0", adj, 0);
    @(posedge clk);
    @(negedge clk);
    check("s6_step_now", step, 1);
    check("s6_adj_stepped", adj, 1);
    cycles(4);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
